// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/STEP/HALTED control and a saturating cycle counter.
// Single-step support is compiled in only when DEBUG_STEP_EN is defined.
module pc_sequencer #(
   parameter int unsigned       N_BITS   = 32,
   parameter logic [N_BITS-1:0] PC_RESET = '0
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_step,
   input  logic              i_halt_instr,
   input  logic              i_stall,
   input  logic              i_branch_taken,
   input  logic [N_BITS-1:0] i_pc_branch,
   input  logic              i_jump_taken,
   input  logic [N_BITS-1:0] i_pc_jump,
   output logic [N_BITS-1:0] o_pc,
   output logic [N_BITS-1:0] o_pc_4,
   output logic              o_flush_if_id,
   output logic [1:0]        o_state,
   output logic [N_BITS-1:0] o_cycle_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   localparam logic [N_BITS-1:0] PC_INC  = N_BITS'(4);
   localparam logic [N_BITS-1:0] CNT_INC = N_BITS'(1);

   state_t            state, state_nx;
   logic [N_BITS-1:0] pc, pc_nx, cnt;
   logic              active, flush;
   logic              unused_bits;

   // Targets are word aligned; the low bits are never consumed.
   assign unused_bits = ^{i_pc_branch[1:0], i_pc_jump[1:0], i_step};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
         pc    <= PC_RESET;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (active && (cnt != '1))
            cnt <= cnt + CNT_INC;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      flush    = 1'b0;
      active   = 1'b0;
      case (state)
         IDLE: begin
            if (i_start)
               state_nx = RUN;
`ifdef DEBUG_STEP_EN
            else if (i_step)
               state_nx = STEP;
`endif
         end
         RUN, STEP: begin
            active = 1'b1;
            if (i_halt_instr) begin
               state_nx = HALTED;
            end else begin
               state_nx = (state == STEP) ? IDLE : RUN;
               if (!i_stall) begin
                  if (i_branch_taken) begin
                     pc_nx = {i_pc_branch[N_BITS-1:2], 2'b00};
                     flush = 1'b1;
                  end else if (i_jump_taken) begin
                     pc_nx = {i_pc_jump[N_BITS-1:2], 2'b00};
                     flush = 1'b1;
                  end else begin
                     pc_nx = pc + PC_INC;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // Reset is folded into the combinational outputs so they are valid before the first reset edge.
   assign o_pc_4        = (i_reset ? PC_RESET : pc) + PC_INC;
   assign o_flush_if_id = flush & ~i_reset;
   assign o_pc          = pc;
   assign o_state       = state;
   assign o_cycle_count = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, an N_BITS=4 wrap/saturation
// sequence, and randomized stimulus against a behavioural model (32-bit and 4-bit builds).
module tb_pc_sequencer;

   typedef struct {
      bit          reset, start, step, halt, stall, br, jmp;
      logic [31:0] pcbr, pcj;
   } in_t;

   typedef struct {
      in_t         i;
      bit          ef;
      logic [63:0] epc;
      int          est;
      logic [63:0] ecnt;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      int          mode;
      logic [63:0] cnt;
   } mdl_t;

`ifdef DEBUG_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic        clk;
   logic        reset, start, step, halt, stall, br, jmp;
   logic [31:0] pcbr, pcj;
   logic [31:0] pc, pc4, cnt;
   logic        flush;
   logic [1:0]  st;
   logic [3:0]  pc_b, pc4_b, cnt_b;
   logic        flush_b;
   logic [1:0]  st_b;

   int n_tests = 0;
   int n_fail  = 0;

   pc_sequencer #(.N_BITS(32)) dut (
      .i_clock(clk), .i_reset(reset), .i_start(start), .i_step(step),
      .i_halt_instr(halt), .i_stall(stall), .i_branch_taken(br), .i_pc_branch(pcbr),
      .i_jump_taken(jmp), .i_pc_jump(pcj), .o_pc(pc), .o_pc_4(pc4),
      .o_flush_if_id(flush), .o_state(st), .o_cycle_count(cnt)
   );

   pc_sequencer #(.N_BITS(4)) dut4 (
      .i_clock(clk), .i_reset(reset), .i_start(start), .i_step(step),
      .i_halt_instr(halt), .i_stall(stall), .i_branch_taken(br), .i_pc_branch(pcbr[3:0]),
      .i_jump_taken(jmp), .i_pc_jump(pcj[3:0]), .o_pc(pc_b), .o_pc_4(pc4_b),
      .o_flush_if_id(flush_b), .o_state(st_b), .o_cycle_count(cnt_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic in_t inp(bit r, bit s, bit sp, bit h, bit sl,
                               bit b, logic [31:0] pb, bit j, logic [31:0] pj);
      in_t x;
      x.reset = r; x.start = s; x.step = sp; x.halt = h; x.stall = sl;
      x.br = b; x.pcbr = pb; x.jmp = j; x.pcj = pj;
      return x;
   endfunction

   task automatic drive(input in_t x);
      reset = x.reset; start = x.start; step = x.step; halt = x.halt; stall = x.stall;
      br = x.br; pcbr = x.pcbr; jmp = x.jmp; pcj = x.pcj;
   endtask

   // Reference: what one clock does, written from the sequencing rules with plain arithmetic.
   function automatic void model(input mdl_t m, input in_t x, input int nb,
                                 output mdl_t n, output bit fl, output logic [63:0] p4);
      logic [63:0] mask, target;
      mask = (64'd1 << nb) - 64'd1;
      n  = m;
      fl = 1'b0;
      p4 = ((x.reset ? 64'd0 : m.pc) + 64'd4) & mask;
      if (x.reset) begin
         n.pc = 0; n.mode = 0; n.cnt = 0;
      end else if (m.mode == 0) begin
         if (x.start)             n.mode = 1;
         else if (x.step && STEP_EN) n.mode = 2;
      end else if (m.mode == 1 || m.mode == 2) begin
         n.cnt = (m.cnt == mask) ? mask : m.cnt + 1;
         if (x.halt) begin
            n.mode = 3;
         end else begin
            n.mode = (m.mode == 2) ? 0 : 1;
            if (!x.stall) begin
               if (x.br || x.jmp) begin
                  target = x.br ? 64'(x.pcbr) : 64'(x.pcj);
                  n.pc   = (target & mask) & ~64'd3;
                  fl     = 1'b1;
               end else begin
                  n.pc = (m.pc + 4) & mask;
               end
            end
         end
      end
   endfunction

   vec_t        tbl[$];
   logic [63:0] cur_pc;
   mdl_t        m32, m4, n32, n4;
   bit          f32, f4;
   logic [63:0] e32, e4;
   in_t         ri;
   in_t         idle;

   task automatic add(input in_t x, input bit ef, input logic [63:0] epc,
                      input int est, input logic [63:0] ecnt);
      vec_t v;
      v.i = x; v.ef = ef; v.epc = epc; v.est = est; v.ecnt = ecnt;
      tbl.push_back(v);
   endtask

   initial begin
      idle = inp(0,0,0,0,0, 0,32'h0, 0,32'h0);
      drive(inp(1,0,0,0,0, 0,32'h0, 0,32'h0));
      @(posedge clk); #1;

      // reset, start, sequential run
      add(inp(1,0,0,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
      add(inp(0,1,0,0,0, 0,0, 0,0), 0, 'h00, 1, 0);
      add(idle, 0, 'h04, 1, 1);
      add(idle, 0, 'h08, 1, 2);
      add(idle, 0, 'h0C, 1, 3);
      add(idle, 0, 'h10, 1, 4);
      // stalled jump, jump, branch+jump, aligned jump, halt
      add(inp(0,0,0,0,1, 0,0, 1,32'h43), 0, 'h10, 1, 5);
      add(inp(0,0,0,0,0, 0,0, 1,32'h43), 1, 'h40, 1, 6);
      add(inp(0,0,0,0,0, 1,32'h80, 1,32'h100), 1, 'h80, 1, 7);
      add(inp(0,0,0,0,0, 0,0, 1,32'h22), 1, 'h20, 1, 8);
      add(inp(0,0,0,1,0, 1,32'h80, 0,0), 0, 'h20, 3, 9);
      for (int unsigned k = 0; k < 10; k++)
         add(inp(0,1,1,0,0, 0,0, 0,0), 0, 'h20, 3, 9);
      add(inp(1,1,0,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
`ifdef DEBUG_STEP_EN
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h00, 2, 0);
      add(idle, 0, 'h04, 0, 1);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h04, 2, 1);
      add(idle, 0, 'h08, 0, 2);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h08, 2, 2);
      add(idle, 0, 'h0C, 0, 3);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h0C, 2, 3);
`else
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
      add(idle, 0, 'h00, 0, 0);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
      add(idle, 0, 'h00, 0, 0);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
      add(idle, 0, 'h00, 0, 0);
      add(inp(0,0,1,0,0, 0,0, 0,0), 0, 'h00, 0, 0);
`endif
      add(inp(1,0,1,0,0, 0,0, 1,32'h40), 0, 'h00, 0, 0);
      add(inp(0,1,1,0,0, 0,0, 0,0), 0, 'h00, 1, 0);
      add(inp(0,0,0,0,0, 0,0, 1,32'hFFFF_FFFF), 1, 'hFFFF_FFFC, 1, 1);
      add(idle, 0, 'h00, 1, 2);
      add(inp(1,0,0,0,0, 0,0, 0,0), 0, 'h00, 0, 0);

      cur_pc = 0;
      for (int unsigned i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].i);
         #3;
         chk($sformatf("tbl%0d flush", i), 64'(flush), 64'(tbl[i].ef));
         chk($sformatf("tbl%0d pc_4", i), 64'(pc4),
             ((tbl[i].i.reset ? 64'd0 : cur_pc) + 64'd4) & 64'hFFFF_FFFF);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d pc", i), 64'(pc), tbl[i].epc);
         chk($sformatf("tbl%0d state", i), 64'(st), 64'(tbl[i].est));
         chk($sformatf("tbl%0d count", i), 64'(cnt), tbl[i].ecnt);
         cur_pc = tbl[i].epc;
      end

      // 4-bit build: sequential PC wraps 0xC -> 0, counter saturates at 0xF
      drive(inp(1,0,0,0,0, 0,0, 0,0));
      @(posedge clk); #1;
      drive(inp(0,1,0,0,0, 0,0, 0,0));
      @(posedge clk); #1;
      for (int unsigned k = 1; k <= 20; k++) begin
         drive(idle);
         #3;
         chk($sformatf("n4 k%0d pc_4", k), 64'(pc4_b), 64'((4 * k) % 16));
         chk($sformatf("n4 k%0d flush", k), 64'(flush_b), 64'd0);
         @(posedge clk); #1;
         chk($sformatf("n4 k%0d pc", k), 64'(pc_b), 64'((4 * k) % 16));
         chk($sformatf("n4 k%0d count", k), 64'(cnt_b), 64'((k > 15) ? 15 : k));
      end

      // randomized run against the model, both widths
      drive(inp(1,0,0,0,0, 0,0, 0,0));
      m32.pc = 0; m32.mode = 0; m32.cnt = 0;
      m4 = m32;
      @(posedge clk); #1;
      for (int unsigned c = 0; c < 3000; c++) begin
         ri = inp($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom);
         drive(ri);
         model(m32, ri, 32, n32, f32, e32);
         model(m4, ri, 4, n4, f4, e4);
         #3;
         chk("rnd flush", 64'(flush), 64'(f32));
         chk("rnd pc_4", 64'(pc4), e32);
         chk("rnd4 flush", 64'(flush_b), 64'(f4));
         chk("rnd4 pc_4", 64'(pc4_b), e4);
         @(posedge clk); #1;
         m32 = n32;
         m4  = n4;
         chk("rnd pc", 64'(pc), m32.pc);
         chk("rnd state", 64'(st), 64'(m32.mode));
         chk("rnd count", 64'(cnt), m32.cnt);
         chk("rnd4 pc", 64'(pc_b), m4.pc);
         chk("rnd4 state", 64'(st_b), 64'(m4.mode));
         chk("rnd4 count", 64'(cnt_b), m4.cnt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter N_BITS, default 32, meaning the width of the PC and the cycle counter.
REQ-002 SHALL have parameter PC_RESET, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port i_clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_start  input  1  debug-unit request to enter continuous run.
REQ-006 SHALL have port i_step  input  1  debug-unit request to advance one cycle.
REQ-007 SHALL have port i_halt_instr  input  1  HALT instruction decoded in ID.
REQ-008 SHALL have port i_stall  input  1  load-use stall request from the hazard unit.
REQ-009 SHALL have port i_branch_taken  input  1  conditional branch resolved taken.
REQ-010 SHALL have port i_pc_branch  input  N_BITS  branch target.
REQ-011 SHALL have port i_jump_taken  input  1  J/JAL/JR/JALR resolved.
REQ-012 SHALL have port i_pc_jump  input  N_BITS  jump target from the jump-target logic.
REQ-013 SHALL have the following outputs: o_pc (N_BITS, current PC), o_pc_4 (N_BITS, o_pc+4), o_flush_if_id (1, squash the IF/ID register), o_state (2, FSM state), o_cycle_count (N_BITS, executed-cycle counter).

Function
REQ-014 SHALL implement FSM states IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11, with o_state equal to the current state register.
REQ-015 IDLE SHALL hold the PC; on i_start go to RUN, else on i_step go to STEP; if both are asserted, i_start SHALL win.
REQ-016 RUN SHALL advance the PC per REQ-019; i_start and i_step SHALL be ignored.
REQ-017 STEP SHALL be active for exactly one cycle, advance the PC once per REQ-019, and then return to IDLE.
REQ-018 In RUN or STEP with i_halt_instr=1, the PC SHALL be held, no flush SHALL occur, and the next state SHALL be HALTED; HALTED SHALL persist until i_reset.
REQ-019 Next-PC priority in RUN and STEP SHALL be: halt (hold) > i_stall (hold) > i_branch_taken (i_pc_branch) > i_jump_taken (i_pc_jump) > sequential (o_pc+4).
REQ-020 The PC SHALL be loaded from a target with bits [1:0] forced to 2'b00.
REQ-021 o_pc_4 SHALL be o_pc+4, combinational, modulo 2^N_BITS; all-ones minus 3 SHALL wrap to 0.
REQ-022 o_flush_if_id SHALL be combinational and equal 1 only in a RUN/STEP cycle where a branch or jump target is loaded; a stall or halt SHALL suppress it.
REQ-023 o_cycle_count SHALL increment on every cycle spent in RUN or STEP, including stalled cycles, and SHALL saturate at all-ones.
REQ-024 Branch and jump asserted together SHALL load i_pc_branch and assert the flush once.

Reset
REQ-025 On i_reset=1 at a clock edge, reset SHALL set o_pc=PC_RESET, o_state=IDLE, o_cycle_count=0.
REQ-026 While i_reset=1, o_flush_if_id SHALL be 0 and o_pc_4 SHALL equal PC_RESET+4.
REQ-027 Reset SHALL override every other input in every state, including HALTED and mid-STEP.

Configuration
REQ-028 SHALL support the macro DEBUG_STEP_EN; when defined, STEP SHALL be reachable and i_step SHALL be honoured per REQ-015/017.
REQ-029 When DEBUG_STEP_EN is undefined, i_step SHALL be ignored, STEP SHALL be unreachable, o_state SHALL never equal 2'b10, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset, then hold i_start=1 for one cycle with no other inputs -> o_state=01, and o_pc=0,4,8,12 on successive cycles with o_flush_if_id=0.
REQ-031 In RUN at o_pc=0x10, i_jump_taken=1 and i_pc_jump=0x43 -> o_flush_if_id=1 that cycle and next o_pc=0x40; i_stall=1 with the same jump -> o_pc stays 0x10 and flush=0.
REQ-032 In RUN, i_branch_taken=1 (0x80) and i_jump_taken=1 (0x100) -> next o_pc=0x80 and flush=1.
REQ-033 In RUN at o_pc=0x20, i_halt_instr=1 -> o_state=11 and o_pc frozen at 0x20 for 10 cycles despite i_start/i_step; then i_reset=1 -> o_pc=0, o_state=00, o_cycle_count=0.
REQ-034 With DEBUG_STEP_EN defined, three i_step pulses from IDLE -> o_pc 0 to 4 to 8 to 12, o_cycle_count=3, and state back in IDLE; without the macro the same stimulus -> o_pc stays 0.
REQ-035 With o_cycle_count preset near all-ones via an N_BITS=4 build -> o_cycle_count holds 4'hF, and o_pc=0xC (N_BITS=4) sequential -> wraps to 0.
